// File: rtl/bsk_led_pkg.sv
// Shared types and default constants for the LED latch-bus scheduler.
package bsk_led_pkg;

    localparam int DEF_NUM_BUF     = 4;
    localparam int DEF_WIDTH       = 16;
    localparam int DEF_SETUP_CYC   = 1;
    localparam int DEF_LE_CYC      = 2;
    localparam int DEF_REFRESH_DIV = 1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_LATCH = 2'd2,
        ST_HOLD  = 2'd3
    } sched_state_e;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsk_led_sched_if.sv
// Command/LED-bus bundle between the indication source and the scheduler.
interface bsk_led_sched_if #(
    parameter int NUM_BUF = 4,
    parameter int WIDTH   = 16
);
    logic [NUM_BUF*WIDTH-1:0] iLedData;
    logic                     iTest;
    logic [WIDTH-1:0]         oLed;
    logic [NUM_BUF-1:0]       oLe;
    logic                     oBusy;
    logic                     oSweepDone;

    modport master (output iLedData, output iTest,
                    input oLed, input oLe, input oBusy, input oSweepDone);
    modport slave  (input iLedData, input iTest,
                    output oLed, output oLe, output oBusy, output oSweepDone);
endinterface

// File: rtl/bsk_led_refresh_timer.sv
// Free-running prescaler; wrap_o is high in the last cycle of each period.
module bsk_led_refresh_timer
    import bsk_led_pkg::*;
#(
    parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
    input  logic clk,
    input  logic iRst,
    output logic wrap_o
);
    localparam int CW = clog2_min1(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count and wrap detection.
    always_comb begin
        wrap_o = (cnt_q == CW'(REFRESH_DIV - 1));
        if (wrap_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bsk_led_sched.sv
// Time-multiplexes NUM_BUF indication words onto one active-low LED bus,
// rewriting only buffers whose value changed or whose refresh is due.
module bsk_led_sched
    import bsk_led_pkg::*;
#(
    parameter int NUM_BUF     = DEF_NUM_BUF,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int LE_CYC      = DEF_LE_CYC,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
    input  logic          clk,
    input  logic          iRst,
    bsk_led_sched_if.slave bus
);
    localparam int IW = clog2_min1(NUM_BUF);
    localparam int CW = clog2_min1((SETUP_CYC > LE_CYC) ? SETUP_CYC : LE_CYC);

    sched_state_e       state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   led_q, led_d;
    logic [NUM_BUF-1:0] le_q, le_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   shadow_q [NUM_BUF];
    logic [NUM_BUF-1:0] forced_q, forced_d;

    logic [WIDTH-1:0]   eff_s [NUM_BUF];
    logic [NUM_BUF-1:0] dirty_s;
    logic               first_vld_s, next_vld_s;
    logic [IW-1:0]      first_idx_s, next_idx_s;
    logic               latch_ev_s;
    logic               wrap_s;

    bsk_led_refresh_timer #(.REFRESH_DIV(REFRESH_DIV)) u_timer (
        .clk    (clk),
        .iRst   (iRst),
        .wrap_o (wrap_s)
    );

    // Effective value and dirty flag per buffer.
    always_comb begin
        for (int k = 0; k < NUM_BUF; k++) begin
            eff_s[k]   = bus.iTest ? {WIDTH{1'b1}} : bus.iLedData[k*WIDTH +: WIDTH];
            dirty_s[k] = (eff_s[k] != shadow_q[k]) || forced_q[k];
        end
    end

    // Lowest dirty index overall, and lowest dirty index above the current one.
    always_comb begin
        first_vld_s = 1'b0;
        first_idx_s = '0;
        next_vld_s  = 1'b0;
        next_idx_s  = '0;
        for (int k = NUM_BUF - 1; k >= 0; k--) begin
            first_vld_s = first_vld_s | dirty_s[k];
            first_idx_s = dirty_s[k] ? IW'(k) : first_idx_s;
            next_vld_s  = next_vld_s | (dirty_s[k] && (k > int'(idx_q)));
            next_idx_s  = (dirty_s[k] && (k > int'(idx_q))) ? IW'(k) : next_idx_s;
        end
    end

    // Sweep sequencer: next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        led_d      = led_q;
        le_d       = '0;
        done_d     = 1'b0;
        latch_ev_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (first_vld_s) begin
                    state_d = ST_SETUP;
                    idx_d   = first_idx_s;
                    led_d   = ~eff_s[first_idx_s];
                    cnt_d   = '0;
                end else begin
                    led_d   = {WIDTH{1'b1}};
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_d    = ST_LATCH;
                    cnt_d      = '0;
                    le_d       = NUM_BUF'(1'b1) << idx_q;
                    latch_ev_s = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            ST_LATCH: begin
                if (cnt_q == CW'(LE_CYC - 1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    le_d    = le_q;
                end
            end
            ST_HOLD: begin
                if (next_vld_s) begin
                    state_d = ST_SETUP;
                    idx_d   = next_idx_s;
                    led_d   = ~eff_s[next_idx_s];
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    led_d   = {WIDTH{1'b1}};
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = {WIDTH{1'b1}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // A refresh wrap wins over the clear so a coincident latch is redone.
    always_comb begin
        for (int k = 0; k < NUM_BUF; k++) begin
            forced_d[k] = wrap_s | (forced_q[k] & ~(latch_ev_s && (idx_q == IW'(k))));
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            led_q   <= {WIDTH{1'b1}};
            le_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            le_q    <= le_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Shadow copies of latched values and pending-refresh flags.
    always_ff @(posedge clk) begin
        if (iRst) begin
            for (int k = 0; k < NUM_BUF; k++) begin
                shadow_q[k] <= '0;
            end
            forced_q <= '1;
        end else begin
            forced_q <= forced_d;
            if (latch_ev_s) begin
                shadow_q[idx_q] <= ~led_q;
            end
        end
    end

    assign bus.oLed       = led_q;
    assign bus.oLe        = le_q;
    assign bus.oBusy      = busy_q;
    assign bus.oSweepDone = done_q;
endmodule
